logic_unit_pipe: RTL and testbench
==================================

# logic_unit_pipe

Parametrised, pipelined successor to the team's two-input gate block: evaluates one of eight bitwise logic operations on two WIDTH-bit operands, selected per transaction by an opcode. Operands enter and results leave through valid/ready handshakes, through a two-stage registered pipeline with full backpressure. It sits between an operand source (bench driver or sequencer) and a result consumer, and replaces the single-bit combinational gate set.

## Interface
- WIDTH, 8: operand and result width in bits, 1 to 64.
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand transaction present.
- in_ready  output  1  block accepts the operand transaction this cycle.
- in_op  input  3  opcode.
- in_a  input  WIDTH  operand a.
- in_b  input  WIDTH  operand b.
- out_valid  output  1  result transaction present.
- out_ready  input  1  consumer accepts the result this cycle.
- out_y  output  WIDTH  result.
- out_op  output  3  opcode that produced out_y.
- out_zero, out_ones, out_parity  output  1 each  flags; present only with LOGIC_UNIT_FLAGS_EN.

## Operation
- Opcodes: 0 AND, 1 OR, 2 NOT a (b ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 BUF a (pass a).
- All operations are bitwise over WIDTH bits; no carries and no width growth.
- Transfer happens on a cycle where valid and ready are both 1, on either side.
- Stage 1 (S1) registers in_op, in_a and in_b. Stage 2 (S2) registers the computed result, the opcode, and the flags.
- Each stage holds a valid bit. Stage advance conditions:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
- in_ready = s1_adv. It is combinational from out_ready and the state; there is no combinational path from in_valid to in_ready.
- Once out_valid is 1, out_y, out_op and the flags stay stable until the result transfers.
- A full pipeline with out_ready=0 holds two results; in_ready=0.
- Ordering is strictly FIFO; no transaction is dropped or duplicated.

## Timing
- Reset values: s1_valid=0, s2_valid=0, out_valid=0, out_y=0, out_op=0, flags=0. in_ready=1 in the first cycle after reset.
- Reset mid-operation discards both in-flight transactions. No output transfer occurs in the reset cycle.
- Latency: input transfer at edge N gives out_valid=1 after edge N+1, i.e. 2 cycles from in_valid to out_valid.
- Throughput: 1 transaction per cycle while out_ready=1.
- Stall: out_ready low for k cycles delays every queued result by k cycles with values unchanged.
- Simultaneous events: output transfer and input accept in the same cycle with a full pipeline is legal. Both stages shift and in_ready stays 1.

## Configuration
- LOGIC_UNIT_FLAGS_EN defined:
  - out_zero = (y == 0)
  - out_ones = (y == all ones)
  - out_parity = XOR-reduce of y
  - Flags are registered in S2 alongside y and follow the same stall rules.
- LOGIC_UNIT_FLAGS_EN undefined: the three flag ports and their logic are absent. Everything else is identical.

## Structure
- Shared package logic_unit_pkg:
  - opcode enum/localparams: OP_AND … OP_BUF
  - OP_W = 3
- Sub-module logic_unit_core: purely combinational, (op, a, b) → y; instantiated between S1 and S2. The pipeline and handshake logic stay in logic_unit_pipe.

## Test plan
All scenarios use WIDTH=8.
- Truth-table sweep: each opcode with a=0xF0, b=0x3C, out_ready=1. Expected y in opcode order: AND 0x30, OR 0xFC, NOT 0x0F, NAND 0xCF, NOR 0x03, XOR 0xCC, XNOR 0x33, BUF 0xF0. Each appears 2 cycles after input, one per cycle back-to-back.
- Backpressure: stream 4 transactions with out_ready=0. Expected: in_ready drops after the 2nd accept. Release out_ready → 4 results in order, none lost or duplicated.
- Hold stability: out_ready=0 for 5 cycles with out_valid=1. Expected: out_y and out_op unchanged every cycle.
- Reset mid-stream: assert rst with 2 transactions in flight. Expected: next cycle out_valid=0, out_y=0, in_ready=1; no stale result emerges afterwards.
- Random valid/ready toggling, 1000 transactions: output sequence equals a reference-model queue.
- Flags (with LOGIC_UNIT_FLAGS_EN): XOR 0xAA,0xAA → zero=1, ones=0, parity=0. XNOR 0xAA,0xAA → zero=0, ones=1, parity=0. BUF 0x01 → parity=1.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// rtl/logic_unit_pkg.sv - opcode encoding shared by the logic unit pipeline
package logic_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_BUF  = 3'd7
  } op_e;

endpackage

// File: rtl/logic_unit_core.sv
// rtl/logic_unit_core.sv - combinational bitwise operation selected by opcode
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op_e'(op))
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_BUF:  y = a;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage valid/ready bitwise logic unit; LOGIC_UNIT_FLAGS_EN adds result flags
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [OP_W-1:0]  out_op
`ifdef LOGIC_UNIT_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_parity
`endif
);

  logic             s1_valid;
  logic [OP_W-1:0]  s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_y;
  logic [OP_W-1:0]  s2_op;
  logic [WIDTH-1:0] core_y;
  logic             s1_adv;
  logic             s2_adv;

  // A stage may load whenever it is empty or its contents move on this cycle.
  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  logic_unit_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op (s1_op),
    .a  (s1_a),
    .b  (s1_b),
    .y  (core_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s2_valid <= 1'b0;
      s2_y     <= '0;
      s2_op    <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_op <= in_op;
          s1_a  <= in_a;
          s1_b  <= in_b;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_y  <= core_y;
          s2_op <= s1_op;
        end
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_y     = s2_y;
  assign out_op    = s2_op;

`ifdef LOGIC_UNIT_FLAGS_EN
  logic s2_zero;
  logic s2_ones;
  logic s2_parity;

  // Flags load under the same condition as s2_y so they stay paired with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_zero   <= 1'b0;
      s2_ones   <= 1'b0;
      s2_parity <= 1'b0;
    end else if (s2_adv && s1_valid) begin
      s2_zero   <= (core_y == '0);
      s2_ones   <= (core_y == {WIDTH{1'b1}});
      s2_parity <= ^core_y;
    end
  end

  assign out_zero   = s2_zero;
  assign out_ones   = s2_ones;
  assign out_parity = s2_parity;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - self-checking bench for logic_unit_pipe; flag checks when LOGIC_UNIT_FLAGS_EN
module tb_logic_unit_pipe;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [2:0]       out_op;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic             out_zero;
  logic             out_ones;
  logic             out_parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  logic_unit_pipe #(
    .WIDTH (WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_op     (out_op)
`ifdef LOGIC_UNIT_FLAGS_EN
    ,
    .out_zero   (out_zero),
    .out_ones   (out_ones),
    .out_parity (out_parity)
`endif
  );

  // Reference: each opcode is a 2-input truth table indexed by {a_bit, b_bit}
  function automatic logic [WIDTH-1:0] model_y(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [3:0]       tt;
    logic [WIDTH-1:0] r;
    case (op)
      3'd0:    tt = 4'b1000;
      3'd1:    tt = 4'b1110;
      3'd2:    tt = 4'b0011;
      3'd3:    tt = 4'b0111;
      3'd4:    tt = 4'b0001;
      3'd5:    tt = 4'b0110;
      3'd6:    tt = 4'b1001;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < WIDTH; i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  task automatic do_reset;
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_y !== 8'h00 || out_op !== 3'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b y=%h op=%0d in_ready=%b, required 0 00 0 1",
               out_valid, out_y, out_op, in_ready);
    end
`ifdef LOGIC_UNIT_FLAGS_EN
    n_checks++;
    if ({out_zero, out_ones, out_parity} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 000", {out_zero, out_ones, out_parity});
    end
`endif
  endtask

  task automatic test_truth_table;
    logic [7:0] exp_y [8];
    exp_y = '{8'h30, 8'hFC, 8'h0F, 8'hCF, 8'h03, 8'hCC, 8'h33, 8'hF0};
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (c < 8) begin
        in_valid = 1'b1;
        in_op    = 3'(c);
        in_a     = 8'hF0;
        in_b     = 8'h3C;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL tt_in_ready cycle %0d: got %b required 1", c, in_ready);
      end
      n_checks++;
      if (c >= 2) begin
        if (out_valid !== 1'b1 || out_y !== exp_y[c-2] || out_op !== 3'(c - 2)) begin
          n_fail++;
          $display("FAIL tt_result op %0d: valid=%b y=%h op=%0d, required 1 %h %0d",
                   c - 2, out_valid, out_y, out_op, exp_y[c-2], c - 2);
        end
      end else if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL tt_latency cycle %0d: out_valid=%b required 0", c, out_valid);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [2:0]       t_op [4];
    logic [WIDTH-1:0] t_a  [4];
    logic [WIDTH-1:0] t_b  [4];
    logic [WIDTH-1:0] e;
    int idx  = 0;
    int nout = 0;
    for (int i = 0; i < 4; i++) begin
      t_op[i] = 3'($urandom);
      t_a[i]  = 8'($urandom);
      t_b[i]  = 8'($urandom);
    end
    do_reset();
    for (int cyc = 0; cyc < 30 && nout < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid  = (idx < 4);
      if (idx < 4) begin
        in_op = t_op[idx];
        in_a  = t_a[idx];
        in_b  = t_b[idx];
      end
      #1;
      if (cyc < 5) begin
        n_checks++;
        if (in_ready !== (cyc < 2)) begin
          n_fail++;
          $display("FAIL bp_in_ready cycle %0d: got %b required %b", cyc, in_ready, cyc < 2);
        end
      end
      if (out_valid && out_ready) begin
        e = model_y(t_op[nout], t_a[nout], t_b[nout]);
        n_checks++;
        if (out_y !== e || out_op !== t_op[nout]) begin
          n_fail++;
          $display("FAIL bp_order #%0d: y=%h op=%0d, required %h %0d",
                   nout, out_y, out_op, e, t_op[nout]);
        end
        nout++;
      end
      if (in_valid && in_ready) idx++;
    end
    n_checks++;
    if (nout != 4) begin
      n_fail++;
      $display("FAIL bp_count: got %0d results, required 4", nout);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_hold;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] e;
    op = 3'd5;
    a  = 8'($urandom);
    b  = ~a;
    e  = model_y(op, a, b);
    do_reset();
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = 8'($urandom);
    in_b     = 8'($urandom);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_y !== e || out_op !== op) begin
        n_fail++;
        $display("FAIL hold cycle %0d: valid=%b y=%h op=%0d, required 1 %h %0d",
                 k, out_valid, out_y, out_op, e, op);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_drain: out_valid=%b required 0 (duplicate)", out_valid);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = 3'($urandom);
      in_a     = 8'($urandom) | 8'h01;
      in_b     = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_y !== 8'h00 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b y=%h in_ready=%b, required 0 00 1",
               out_valid, out_y, in_ready);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_stale cycle %0d: out_valid=%b required 0", k, out_valid);
      end
    end
  endtask

  task automatic test_random;
    logic [2+WIDTH:0] exp_q [$];
    logic [2+WIDTH:0] e;
    int  sent = 0;
    int  got  = 0;
    bit  acc  = 0;
    do_reset();
    for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
      @(negedge clk);
      if (acc) in_valid = 1'b0;
      acc = 0;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_op    = 3'($urandom);
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
      end
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_spurious: y=%h op=%0d with empty reference queue", out_y, out_op);
        end else begin
          e = exp_q.pop_front();
          if ({out_op, out_y} !== e) begin
            n_fail++;
            $display("FAIL rand_seq #%0d: op=%0d y=%h, required op=%0d y=%h",
                     got, out_op, out_y, e[2+WIDTH:WIDTH], e[WIDTH-1:0]);
          end
`ifdef LOGIC_UNIT_FLAGS_EN
          n_checks++;
          if ({out_zero, out_ones, out_parity} !==
              {e[WIDTH-1:0] == 8'h00, e[WIDTH-1:0] == 8'hFF, ^e[WIDTH-1:0]}) begin
            n_fail++;
            $display("FAIL rand_flags #%0d: got %b for y=%h", got,
                     {out_zero, out_ones, out_parity}, e[WIDTH-1:0]);
          end
`endif
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({in_op, model_y(in_op, in_a, in_b)});
        sent++;
        acc = 1;
      end
    end
    n_checks++;
    if (got != 1000 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_count: got %0d results, %0d left in queue, required 1000 and 0",
               got, exp_q.size());
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

`ifdef LOGIC_UNIT_FLAGS_EN
  task automatic test_flags;
    logic [2:0] f_op [3];
    logic [7:0] f_a  [3];
    logic [7:0] f_y  [3];
    logic [2:0] f_fl [3];
    f_op = '{3'd5, 3'd6, 3'd7};
    f_a  = '{8'hAA, 8'hAA, 8'h01};
    f_y  = '{8'h00, 8'hFF, 8'h01};
    f_fl = '{3'b100, 3'b010, 3'b001};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (c < 3);
      if (c < 3) begin
        in_op = f_op[c];
        in_a  = f_a[c];
        in_b  = (c < 2) ? 8'hAA : 8'h00;
      end
      #1;
      if (c >= 2) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_y !== f_y[c-2] ||
            {out_zero, out_ones, out_parity} !== f_fl[c-2]) begin
          n_fail++;
          $display("FAIL flags op %0d: valid=%b y=%h zop=%b, required 1 %h %b", f_op[c-2],
                   out_valid, out_y, {out_zero, out_ones, out_parity}, f_y[c-2], f_fl[c-2]);
        end
      end
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    test_reset();
    test_truth_table();
    test_backpressure();
    test_hold();
    test_reset_mid();
    test_random();
`ifdef LOGIC_UNIT_FLAGS_EN
    test_flags();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
